seq_divider: RTL

Parametrised multi-cycle restoring divider: a 2N-bit dividend divided by an N-bit divisor, producing an N-bit quotient and N-bit remainder. Successor to the fixed 64/32 divider, adding:
- width parameter;
- runtime signed/unsigned mode;
- start/busy/done handshake;
- divide-by-zero and overflow flags.

It sits beside the datapath as a shared long-latency arithmetic unit, started by a controller and polled or waited on via `done`.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 20 ++
 rtl/seq_divider.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } div_state_t;

  // Constant-foldable ceiling log2, used to size the step counter.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   pr_i,
  input  logic [N-1:0] dvsor_i,
  output logic [N-1:0] rem_o,
  output logic         qbit_o
);

  logic [N+1:0] diff;

  // pr_i is already shifted left by one, so it can reach 2*dvsor-1; the extra bit keeps that carry.
  always_comb begin
    diff   = {1'b0, pr_i} - {2'b00, dvsor_i};
    qbit_o = ~diff[N+1];
    rem_o  = qbit_o ? diff[N-1:0] : pr_i[N-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle 2N/N restoring divider with signed/unsigned mode, start/done handshake and flags.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           sgn,
  input  logic [2*N-1:0] dvdend,
  input  logic [N-1:0]   dvsor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quot,
  output logic [N-1:0]   rem,
  output logic           divz,
  output logic           ovf
);

  localparam int CW = clog2(N + 1);

  div_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] pr_q, pr_d;
  logic [N-1:0]   dvsor_q, dvsor_d;
  logic           sgn_q, sgn_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic           divz_pend_q, divz_pend_d;
  logic           ovf_pend_q, ovf_pend_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           divz_q, divz_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;

  logic           dvdend_neg, dvsor_neg, is_divz, is_early_ovf, late_ovf;
  logic [2*N-1:0] dvdend_mag;
  logic [N-1:0]   dvsor_mag, q_mag, r_mag;
  logic [N-1:0]   step_rem;
  logic           step_qbit;

  div_step #(.N(N)) u_step (
    .pr_i    (pr_q[2*N-1:N-1]),
    .dvsor_i (dvsor_q),
    .rem_o   (step_rem),
    .qbit_o  (step_qbit)
  );

  always_comb begin
    dvdend_neg   = sgn & dvdend[2*N-1];
    dvsor_neg    = sgn & dvsor[N-1];
    dvdend_mag   = dvdend_neg ? -dvdend : dvdend;
    dvsor_mag    = dvsor_neg ? -dvsor : dvsor;
    is_divz      = (dvsor == '0);
    // The quotient needs more than N bits exactly when the upper dividend half already covers the divisor.
    is_early_ovf = !is_divz && (dvdend_mag[2*N-1:N] >= dvsor_mag);
    q_mag        = pr_q[N-1:0];
    r_mag        = pr_q[2*N-1:N];
    late_ovf     = sgn_q && (qneg_q ? (q_mag > {1'b1, {(N-1){1'b0}}}) : q_mag[N-1]);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pr_d        = pr_q;
    dvsor_d     = dvsor_q;
    sgn_d       = sgn_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    divz_pend_d = divz_pend_q;
    ovf_pend_d  = ovf_pend_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    divz_d      = divz_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvsor_d     = dvsor_mag;
          sgn_d       = sgn;
          qneg_d      = dvdend_neg ^ dvsor_neg;
          rneg_d      = dvdend_neg;
          divz_pend_d = is_divz;
          ovf_pend_d  = is_early_ovf;
          cnt_d       = '0;
          pr_d        = is_divz ? {dvdend[N-1:0], {N{1'b0}}} : dvdend_mag;
          state_d     = (is_divz || is_early_ovf) ? FIX : RUN;
        end
      end

      RUN: begin
        pr_d  = {step_rem, pr_q[N-2:0], step_qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = FIX;
      end

      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        divz_d  = divz_pend_q;
        ovf_d   = 1'b0;
        if (divz_pend_q) begin
          quot_d = '1;
          rem_d  = r_mag;
        end else if (ovf_pend_q || late_ovf) begin
          quot_d = '0;
          rem_d  = '0;
          ovf_d  = 1'b1;
        end else begin
          quot_d = qneg_q ? -q_mag : q_mag;
          rem_d  = rneg_q ? -r_mag : r_mag;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pr_q        <= '0;
      dvsor_q     <= '0;
      sgn_q       <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      divz_pend_q <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      divz_q      <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pr_q        <= pr_d;
      dvsor_q     <= dvsor_d;
      sgn_q       <= sgn_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      divz_pend_q <= divz_pend_d;
      ovf_pend_q  <= ovf_pend_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      divz_q      <= divz_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;
  assign divz = divz_q;
  assign ovf  = ovf_q;

endmodule
